led_bcd_display: RTL and testbench
==================================

Name: led_bcd_display

Overview:
- Consumes the CPU's 8-bit `leds` output and shows it as a decimal number on a 3-digit multiplexed seven-segment display.
- Sits directly downstream of `mips.leds` in the board top.
- A sequential double-dabble converter turns the binary value into BCD. A scan engine time-multiplexes the three digits, with leading-zero blanking.

Parameters:
- SCAN_DIV, 50000: clk cycles each digit stays lit. Legal range ≥2; benches use 4.
- SEG_ACTIVE_LOW, 1: 1 = seg and an outputs are active-low; 0 = active-high.
- BLANK_LEADING, 1: 1 = suppress leading zeros; 0 = always show all three digits.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous and active-high. Asserting it immediately forces reset values.
- value  in  8  binary value to display; connects to `mips.leds`.
- bcd  out  12  {hundreds, tens, ones}, registered.
- bcd_valid  out  1  one-cycle pulse when `bcd` is updated.
- busy  out  1  high while a conversion is in progress.
- seg  out  7  segments {g,f,e,d,c,b,a}, registered.
- an  out  3  digit enables, one-hot when lit. an[0]=ones, an[1]=tens, an[2]=hundreds.

Behaviour:
- Reset values:
  - bcd=0, bcd_valid=0, busy=0.
  - last_val=0, FSM=IDLE, scan counter=0, digit index=0.
  - an and seg all inactive: all 1s if SEG_ACTIVE_LOW, else all 0s.
- Converter FSM states: IDLE, SHIFT, DONE.
  - IDLE: if value != last_val, capture value into cap. Load shreg[19:0] = {12'b0, value}, cnt=0, go to SHIFT, busy=1. Otherwise stay in IDLE.
  - SHIFT, each cycle:
    - Add 3 to every BCD nibble of shreg[19:8] that is ≥5.
    - Then shift shreg left by 1 and increment cnt.
    - After the 8th shift (cnt was 7), go to DONE.
  - DONE: bcd <= shreg[19:8], last_val <= cap, bcd_valid=1 for this cycle only, busy=0, go to IDLE.
- Latency: bcd and bcd_valid update on the 9th rising edge after the capture edge. The minimum IDLE-to-IDLE period is 10 cycles.
- value changes while busy are ignored. In IDLE it is re-compared against last_val, so the final settled value is always converted. There is no input synchronizer, since value is on the same clock.
- Reset mid-conversion aborts the conversion: bcd stays 0 and there is no bcd_valid pulse.
- value=0 after reset causes no conversion, because last_val is already 0. The display shows "0".
- Arithmetic: a max input of 255 requires 10 bits of BCD. bcd[11:10] is always 0, and the hundreds nibble is ≤2.
- Scan engine:
  - The counter counts 0..SCAN_DIV-1. On terminal count it wraps to 0 and the digit index advances 0→1→2→0.
  - an and seg are registered on that same edge from the new index. They are therefore inactive until the first terminal count after reset.
- Blanking (BLANK_LEADING=1):
  - Hundreds digit is blanked if it is 0.
  - Tens digit is blanked if hundreds and tens are both 0.
  - The ones digit is never blanked.
  - A blanked slot drives an and seg inactive, but still consumes its time slot.
- Segment map (active-high, gfedcba): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F. Nibbles >9 cannot occur; decode them as blank. SEG_ACTIVE_LOW inverts both seg and an.
- The scan engine reads the registered bcd. A bcd update mid-slot takes effect at the next slot boundary, so a digit is never partially redrawn.

Test Plan:
- Directed scenarios use SCAN_DIV=4 and SEG_ACTIVE_LOW=1.
- Reset, then hold value=0 → bcd=0x000, busy and bcd_valid never assert. The ones slot shows an=3'b110, seg=7'h40; the other two slots have an=3'b111.
- value 0→15 → capture next edge, busy=1 for 9 cycles, bcd_valid pulses on the 9th edge with bcd=0x015. Scan results:
  - ones: seg=7'h12, an=3'b110
  - tens: seg=7'h79, an=3'b101
  - hundreds: blanked, an=3'b111
- value=255 → bcd=0x255. All three digits lit; the hundreds slot has seg=7'h24, an=3'b011.
- value=15, then 200 three cycles after capture → first bcd_valid with 0x015. A second conversion starts the cycle after DONE; its bcd_valid carries 0x200 exactly 10 cycles after the first.
- Assert rst during SHIFT (value=99) → all outputs return to reset values immediately with no bcd_valid. After release with value still 99, a fresh conversion yields bcd=0x099 9 cycles after capture.
- BLANK_LEADING=0, value=7 → the scan shows seg 7'h40 (0), 7'h40 (0), 7'h78 (7) across the three slots, all digits lit.

Source files
------------

// File: rtl/led_bcd_display.sv
// Shows an 8-bit binary value as up to three decimal digits on a multiplexed
// seven-segment display. A sequential double-dabble converter feeds a scan engine.
module led_bcd_display #(
  parameter int SCAN_DIV       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit BLANK_LEADING  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  value,
  output logic [11:0] bcd,
  output logic        bcd_valid,
  output logic        busy,
  output logic [6:0]  seg,
  output logic [2:0]  an
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [2:0] AN_OFF  = SEG_ACTIVE_LOW ? 3'b111 : 3'b000;

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  state_t        state_q;
  logic [7:0]    cap_q, last_q;
  logic [19:0]   shreg_q, shreg_d, adj_s;
  logic [2:0]    cnt_q;
  logic [11:0]   bcd_q;
  logic          valid_q, busy_q;

  logic [CW-1:0] scan_q;
  logic [1:0]    idx_q, idx_d;
  logic [6:0]    seg_q, seg_d, seg_raw_s;
  logic [2:0]    an_q, an_d, an_raw_s;
  logic [3:0]    nib_s;
  logic          blank_s;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  // Double-dabble step: correct every BCD nibble >= 5, then shift left.
  always_comb begin
    adj_s = shreg_q;
    for (int i = 0; i < 3; i++) begin
      if (adj_s[8+4*i +: 4] >= 4'd5) adj_s[8+4*i +: 4] = adj_s[8+4*i +: 4] + 4'd3;
      else                           adj_s[8+4*i +: 4] = adj_s[8+4*i +: 4];
    end
    shreg_d = {adj_s[18:0], 1'b0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cap_q   <= 8'd0;
      last_q  <= 8'd0;
      shreg_q <= 20'd0;
      cnt_q   <= 3'd0;
      bcd_q   <= 12'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (value != last_q) begin
            cap_q   <= value;
            shreg_q <= {12'd0, value};
            cnt_q   <= 3'd0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          shreg_q <= shreg_d;
          cnt_q   <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_q <= DONE;
        end
        DONE: begin
          bcd_q   <= shreg_q[19:8];
          last_q  <= cap_q;
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Digit for the slot about to start; blanking only ever hides leading zeros.
  always_comb begin
    idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    case (idx_d)
      2'd0: begin nib_s = bcd_q[3:0];  an_raw_s = 3'b001; blank_s = 1'b0; end
      2'd1: begin
        nib_s    = bcd_q[7:4];
        an_raw_s = 3'b010;
        blank_s  = BLANK_LEADING && (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
      end
      2'd2: begin
        nib_s    = bcd_q[11:8];
        an_raw_s = 3'b100;
        blank_s  = BLANK_LEADING && (bcd_q[11:8] == 4'd0);
      end
      default: begin nib_s = 4'd0; an_raw_s = 3'b000; blank_s = 1'b1; end
    endcase
    seg_raw_s = blank_s ? 7'h00 : seg7(nib_s);
    if (blank_s) an_raw_s = 3'b000;
    else         an_raw_s = an_raw_s;
    seg_d = SEG_ACTIVE_LOW ? ~seg_raw_s : seg_raw_s;
    an_d  = SEG_ACTIVE_LOW ? ~an_raw_s  : an_raw_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_q <= '0;
      idx_q  <= 2'd0;
      seg_q  <= SEG_OFF;
      an_q   <= AN_OFF;
    end else if (scan_q == CW'(SCAN_DIV - 1)) begin
      scan_q <= '0;
      idx_q  <= idx_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
    end else begin
      scan_q <= scan_q + CW'(1);
    end
  end

  assign bcd       = bcd_q;
  assign bcd_valid = valid_q;
  assign busy      = busy_q;
  assign seg       = seg_q;
  assign an        = an_q;

endmodule

// File: tb/tb_led_bcd_display.sv
// Bench for led_bcd_display: table of values with expected BCD and scan pattern,
// scoreboard queue for bcd_valid results, plus hand-written timing/reset sequences.
module tb_led_bcd_display;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  value = 8'd0;
  logic [7:0]  value_nb = 8'd0;
  logic [11:0] bcd, bcd_nb;
  logic        bcd_valid, bcd_valid_nb, busy, busy_nb;
  logic [6:0]  seg, seg_nb;
  logic [2:0]  an, an_nb;

  int n_checks = 0;
  int n_err = 0;
  int tb_cyc;
  logic [11:0] sb_q[$];

  led_bcd_display #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b1)) dut (
    .clk(clk), .rst(rst), .value(value), .bcd(bcd), .bcd_valid(bcd_valid),
    .busy(busy), .seg(seg), .an(an)
  );

  led_bcd_display #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .value(value_nb), .bcd(bcd_nb), .bcd_valid(bcd_valid_nb),
    .busy(busy_nb), .seg(seg_nb), .an(an_nb)
  );

  always #5 clk = ~clk;

  // Edges since reset release; slot boundaries fall on multiples of 4.
  always @(posedge clk or posedge rst) begin
    if (rst) tb_cyc <= 0;
    else     tb_cyc <= tb_cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] bcd_of(input logic [7:0] v);
    int h, t, o;
    h = v / 100; t = (v / 10) % 10; o = v % 10;
    return {h[3:0], t[3:0], o[3:0]};
  endfunction

  // Scoreboard: every bcd_valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst && bcd_valid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL sb_unexpected_valid: got bcd %0h expected no pulse", bcd);
      end else begin
        chk("sb_bcd", {20'd0, bcd}, {20'd0, sb_q.pop_front()});
      end
    end
  end

  task automatic wait_valid(input int n0, input int exp_n, input string name);
    int n;
    n = n0;
    while (!bcd_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_latency"}, n, exp_n);
  endtask

  task automatic convert(input logic [7:0] v, input string name);
    value = v;
    sb_q.push_back(bcd_of(v));
    @(negedge clk);
    chk({name, "_busy_rise"}, {31'd0, busy}, 32'd1);
    wait_valid(1, 10, name);
    chk({name, "_busy_fall"}, {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk({name, "_valid_pulse"}, {31'd0, bcd_valid}, 32'd0);
  endtask

  task automatic check_scan(input bit sel,
                            input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                            input logic [2:0] a0, input logic [2:0] a1, input logic [2:0] a2,
                            input string name);
    logic [9:0] exp, act;
    int slot;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (tb_cyc % 4 == 0) begin
        slot = (tb_cyc / 4) % 3;
        exp = (slot == 0) ? {a0, s0} : (slot == 1) ? {a1, s1} : {a2, s2};
        act = sel ? {an_nb, seg_nb} : {an, seg};
        chk($sformatf("%s_slot%0d", name, slot), {22'd0, act}, {22'd0, exp});
      end
    end
  endtask

  typedef struct {
    logic [7:0]  v;
    logic [6:0]  s0, s1, s2;
    logic [2:0]  a0, a1, a2;
  } vec_t;

  vec_t vecs[6];

  initial begin
    bit saw;
    int t1, t2, n;

    vecs[0] = '{8'd15,  7'h12, 7'h79, 7'h7F, 3'b110, 3'b101, 3'b111};
    vecs[1] = '{8'd255, 7'h12, 7'h12, 7'h24, 3'b110, 3'b101, 3'b011};
    vecs[2] = '{8'd100, 7'h40, 7'h40, 7'h79, 3'b110, 3'b101, 3'b011};
    vecs[3] = '{8'd7,   7'h78, 7'h7F, 7'h7F, 3'b110, 3'b111, 3'b111};
    vecs[4] = '{8'd99,  7'h10, 7'h10, 7'h7F, 3'b110, 3'b101, 3'b111};
    vecs[5] = '{8'd0,   7'h40, 7'h7F, 7'h7F, 3'b110, 3'b111, 3'b111};

    // Reset values
    #12;
    chk("rst_bcd", {20'd0, bcd}, 32'h000);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, bcd_valid}, 32'd0);
    chk("rst_an", {29'd0, an}, 32'h7);
    chk("rst_seg", {25'd0, seg}, 32'h7F);
    @(negedge clk);
    rst = 1'b0;

    // value stays 0: no conversion, display shows a single "0"
    saw = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      saw |= busy | bcd_valid;
    end
    chk("zero_no_busy", {31'd0, saw}, 32'd0);
    chk("zero_bcd", {20'd0, bcd}, 32'h000);
    check_scan(1'b0, 7'h40, 7'h7F, 7'h7F, 3'b110, 3'b111, 3'b111, "zero_scan");

    for (int i = 0; i < 6; i++) begin
      convert(vecs[i].v, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_bcd", i), {20'd0, bcd}, {20'd0, bcd_of(vecs[i].v)});
      check_scan(1'b0, vecs[i].s0, vecs[i].s1, vecs[i].s2,
                 vecs[i].a0, vecs[i].a1, vecs[i].a2, $sformatf("vec%0d_scan", i));
    end

    // Back-to-back: change during busy is picked up right after DONE
    value = 8'd15;
    sb_q.push_back(bcd_of(8'd15));
    repeat (4) @(negedge clk);
    value = 8'd200;
    sb_q.push_back(bcd_of(8'd200));
    n = 4;
    while (!bcd_valid && n < 40) begin @(negedge clk); n++; end
    chk("b2b_first_latency", n, 10);
    t1 = tb_cyc;
    @(negedge clk);
    n = 0;
    while (!bcd_valid && n < 40) begin @(negedge clk); n++; end
    t2 = tb_cyc;
    chk("b2b_spacing", t2 - t1, 10);
    chk("b2b_bcd", {20'd0, bcd}, 32'h200);

    // Reset in SHIFT aborts; re-conversion after release
    value = 8'd99;
    sb_q.push_back(bcd_of(8'd99));
    repeat (3) @(negedge clk);
    chk("abort_in_shift", {31'd0, busy}, 32'd1);
    #2;
    rst = 1'b1;
    sb_q.delete();
    #1;
    chk("abort_bcd", {20'd0, bcd}, 32'h000);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_an", {29'd0, an}, 32'h7);
    chk("abort_seg", {25'd0, seg}, 32'h7F);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    sb_q.push_back(bcd_of(8'd99));
    wait_valid(0, 10, "rearm");
    chk("rearm_bcd", {20'd0, bcd}, 32'h099);

    // No blanking: all three digits lit
    value_nb = 8'd7;
    n = 0;
    while (!bcd_valid_nb && n < 40) begin @(negedge clk); n++; end
    chk("nb_latency", n, 10);
    chk("nb_bcd", {20'd0, bcd_nb}, 32'h007);
    check_scan(1'b1, 7'h78, 7'h40, 7'h40, 3'b110, 3'b101, 3'b011, "nb_scan");

    repeat (12) @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
